// File: rtl/chunked_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, CHUNK bits per clock with a registered
// ripple carry between chunks, valid/ready handshakes on both sides.
module chunked_adder #(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [CHUNK-1:0] s_d;
  logic             c_d;
  logic             top_cin;
  logic             ovf_d;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    s_d       = chunk_res[CHUNK-1:0];
    c_d       = chunk_res[CHUNK];
    // Carry into the chunk's top bit recovered from its sum bit; valid for CHUNK == 1 too.
    top_cin   = s_d[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    ovf_d     = SIGNED ? (top_cin ^ c_d) : c_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NCH; k++) begin
            if (idx_q == IW'(k)) begin
              sum_q[k*CHUNK +: CHUNK] <= s_d;
            end
          end
          carry_q <= c_d;
          if (idx_q == LAST_IDX) begin
            cout_q  <= c_d;
            ovf_q   <= ovf_d;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: five instances covering 32/8 (both SIGNED),
// 32/32 and an exhaustive 4/1 sweep with random output backpressure.
module tb_chunked_adder;

  logic clk;
  logic rst_n;

  logic [4:0]  iv, orr, tc;
  logic [4:0]  ir, ov, co, of;
  logic [31:0] ta [5];
  logic [31:0] tb [5];
  logic [31:0] ts0, ts1, ts2;
  logic [3:0]  ts3, ts4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc [5] = '{default: 0};
  int n_hs  [5] = '{default: 0};

  chunked_adder #(.WIDTH(32), .CHUNK(8), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[0]), .b(tb[0]),
    .cin(tc[0]), .out_valid(ov[0]), .out_ready(orr[0]), .sum(ts0), .cout(co[0]), .ovf(of[0]));
  chunked_adder #(.WIDTH(32), .CHUNK(8), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[1]), .b(tb[1]),
    .cin(tc[1]), .out_valid(ov[1]), .out_ready(orr[1]), .sum(ts1), .cout(co[1]), .ovf(of[1]));
  chunked_adder #(.WIDTH(32), .CHUNK(32), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[2]), .b(tb[2]),
    .cin(tc[2]), .out_valid(ov[2]), .out_ready(orr[2]), .sum(ts2), .cout(co[2]), .ovf(of[2]));
  chunked_adder #(.WIDTH(4), .CHUNK(1), .SIGNED(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a(ta[3][3:0]), .b(tb[3][3:0]),
    .cin(tc[3]), .out_valid(ov[3]), .out_ready(orr[3]), .sum(ts3), .cout(co[3]), .ovf(of[3]));
  chunked_adder #(.WIDTH(4), .CHUNK(1), .SIGNED(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .a(ta[4][3:0]), .b(tb[4][3:0]),
    .cin(tc[4]), .out_valid(ov[4]), .out_ready(orr[4]), .sum(ts4), .cout(co[4]), .ovf(of[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (iv[i] && ir[i]) n_acc[i] <= n_acc[i] + 1;
      if (ov[i] && orr[i]) n_hs[i] <= n_hs[i] + 1;
    end
  end

  function automatic logic [31:0] get_sum(input int i);
    case (i)
      0:       return ts0;
      1:       return ts1;
      2:       return ts2;
      3:       return {28'h0, ts3};
      default: return {28'h0, ts4};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic wait_valid(input int i, output int lat);
    lat = 0;
    while (!ov[i] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input int i, input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input logic [31:0] es, input logic ec, input logic eo, input int elat,
                       input bit rnd, input string tag);
    int lat;
    int guard;
    bit hs;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(ir[i]), 32'd1);
    iv[i] = 1'b1; ta[i] = av; tb[i] = bv; tc[i] = cv;
    @(posedge clk);
    @(negedge clk);
    iv[i] = 1'b0; ta[i] = ~av; tb[i] = ~bv; tc[i] = ~cv;
    wait_valid(i, lat);
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".sum"}, get_sum(i), es);
    check({tag, ".cout"}, 32'(co[i]), 32'(ec));
    check({tag, ".ovf"}, 32'(of[i]), 32'(eo));
    $display("[%0t] %s inst%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             $time, tag, i, av, bv, cv, get_sum(i), co[i], of[i], lat);
    hs = 1'b0;
    guard = 0;
    while (!hs && guard < 50) begin
      orr[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      hs = orr[i] && ov[i];
      @(negedge clk);
      guard++;
    end
    orr[i] = 1'b0;
    check({tag, ".handshake"}, 32'(hs), 32'd1);
    check({tag, ".idle_after"}, {30'h0, ov[i], ir[i]}, 32'b01);
    if (!rnd) check({tag, ".sum_kept"}, get_sum(i), es);
  endtask

  initial begin
    int lat;
    int acc0;
    int sa, sb, t;
    logic [31:0] es;
    rst_n = 1'b0;
    iv = '0; orr = '0; tc = '0;
    for (int i = 0; i < 5; i++) begin ta[i] = '0; tb[i] = '0; end

    // Reset state, observed while reset is still held
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst.inst%0d.ready_valid", i), {30'h0, ov[i], ir[i]}, 32'b01);
      check($sformatf("rst.inst%0d.sum", i), get_sum(i), 32'h0);
      check($sformatf("rst.inst%0d.flags", i), {30'h0, co[i], of[i]}, 32'h0);
    end
    rst_n = 1'b1;

    do_op(0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 4, 1'b0, "t1.u");
    do_op(1, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 4, 1'b0, "t1.s");
    do_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 4, 1'b0, "t2.u");
    do_op(1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 4, 1'b0, "t2.s");
    do_op(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 4, 1'b0, "t3.pos_ovf");
    do_op(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 4, 1'b0, "t3.wrap");
    do_op(0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 4, 1'b0, "mix.u");
    do_op(1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 4, 1'b0, "mix.s");
    do_op(0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 4, 1'b0, "neg.u");
    do_op(1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 4, 1'b0, "neg.s");
    do_op(2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1, 1'b0, "one_chunk.ripple");
    do_op(2, 32'h00010000, 32'h0000FFFF, 1'b0, 32'h0001FFFF, 1'b0, 1'b0, 1, 1'b0, "one_chunk.plain");

    // Backpressure: result must hold and fresh operands must be ignored
    @(negedge clk);
    iv[0] = 1'b1; ta[0] = 32'd1; tb[0] = 32'd2; tc[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    wait_valid(0, lat);
    check("bp.latency", 32'(lat), 32'd4);
    acc0 = n_acc[0];
    ta[0] = 32'hDEADBEEF; tb[0] = 32'h12345678; tc[0] = 1'b1; iv[0] = 1'b1; orr[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp.c%0d.valid_ready", k), {30'h0, ov[0], ir[0]}, 32'b10);
      check($sformatf("bp.c%0d.sum", k), ts0, 32'd3);
      check($sformatf("bp.c%0d.flags", k), {30'h0, co[0], of[0]}, 32'h0);
    end
    check("bp.not_taken", 32'(n_acc[0]), 32'(acc0));
    $display("[%0t] bp inst0 held sum=%h for 10 cycles", $time, ts0);
    ta[0] = 32'd10; tb[0] = 32'd20; tc[0] = 1'b0; orr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    orr[0] = 1'b0;
    check("bp.release.idle", {30'h0, ov[0], ir[0]}, 32'b01);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    check("bp.next.accepted", 32'(n_acc[0]), 32'(acc0 + 1));
    wait_valid(0, lat);
    check("bp.next.latency", 32'(lat), 32'd4);
    check("bp.next.sum", ts0, 32'd30);
    $display("[%0t] bp.next inst0 a=10 b=20 -> sum=%h lat=%0d", $time, ts0, lat);
    orr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    orr[0] = 1'b0;

    // Reset pulse while inst0 sits at idx 2
    @(negedge clk);
    iv[0] = 1'b1; ta[0] = 32'h11111111; tb[0] = 32'h22222222; tc[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid.partial_sum", ts0, 32'h00003333);
    rst_n = 1'b0;
    #1;
    check("rst_mid.ready_valid", {30'h0, ov[0], ir[0]}, 32'b01);
    check("rst_mid.sum", ts0, 32'h0);
    check("rst_mid.flags", {30'h0, co[0], of[0]}, 32'h0);
    #1;
    rst_n = 1'b1;
    $display("[%0t] rst_mid inst0 aborted at idx 2", $time);
    do_op(0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, 4, 1'b0, "rst_mid.next");

    // Exhaustive 4-bit sweep, one bit per cycle, random output backpressure
    for (int i = 3; i < 5; i++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          for (int cv = 0; cv < 2; cv++) begin
            sa = (av >= 8) ? av - 16 : av;
            sb = (bv >= 8) ? bv - 16 : bv;
            t  = sa + sb + cv;
            es = 32'((av + bv + cv) % 16);
            do_op(i, 32'(av), 32'(bv), 1'(cv), es, 1'((av + bv + cv) / 16),
                  (i == 4) ? ((t > 7) || (t < -8)) : 1'((av + bv + cv) / 16),
                  4, 1'b1, $sformatf("sweep%0d", i));
          end
        end
      end
      check($sformatf("sweep%0d.accepts", i), 32'(n_acc[i]), 32'd512);
      check($sformatf("sweep%0d.out_vs_acc", i), 32'(n_hs[i]), 32'(n_acc[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
